tf_unit_sched: RTL and testbench
================================

Name: tf_unit_sched

Overview:
- Scheduler that shares one arithmetic function unit between N_REQ requesters.
- The unit implements three operations: sum (8-bit add), double (4-bit doubling) and no_args (constant 1).
- Round-robin arbitration; one operation in flight at a time; registered result returned over a valid/ready response channel.
- Sits between task-level stimulus/requester blocks and the shared datapath in vlog tfcall regression designs.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), width of the response requester id (derived; do not override).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester accept; at most one bit high.
- req_op  input  2*N_REQ  packed opcodes; requester i uses bits [2i+1:2i].
- req_a  input  8*N_REQ  packed operand A, 8 bits per requester.
- req_b  input  8*N_REQ  packed operand B, 8 bits per requester.
- resp_valid  output  1  result valid.
- resp_ready  input  1  consumer accepts the result.
- resp_id  output  ID_W  index of the requester that owns the result.
- resp_data  output  8  result.
- resp_err  output  1  illegal opcode flag.
- busy  output  1  high whenever the FSM is not in IDLE.
- op_count  output  16  number of completed response handshakes; wraps modulo 2^16.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all outputs 0.
  - rr pointer last_grant=N_REQ-1, so requester 0 has top priority after reset.
  - op_count=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid, grant the first set bit searching from last_grant+1 (wrapping).
  - req_ready[g]=1 combinationally in the same cycle.
  - Latch op/a/b/g, set last_grant=g, go to EXEC.
  - If no req_valid, stay in IDLE with req_ready=0.
- EXEC (one cycle):
  - Compute and register resp_data, resp_err and resp_id.
  - resp_valid goes high on entry to RESP. Latency from grant to resp_valid is 2 cycles.
- Opcode results:
  - SUM (2'b00): (a+b) mod 256.
  - DOUBLE (2'b01): {4'b0, (a[3:0]*2) mod 16}; B is ignored.
  - NO_ARGS (2'b10): 8'd1; A and B are ignored.
  - 2'b11: resp_data=0, resp_err=1.
- RESP:
  - Hold resp_valid, resp_data, resp_id and resp_err stable until resp_ready.
  - On handshake: op_count++, resp_valid=0, go to IDLE. Minimum spacing between grants is 3 cycles.
- Handshake rules:
  - req_ready is 0 in EXEC and RESP.
  - A requester may drop req_valid without penalty before it is granted.
  - Requests are never lost once granted.
- Simultaneous events:
  - All requesters valid → grants rotate 0,1,2,3,0…
  - A requester re-asserting immediately after its own grant waits behind every other pending requester.
- Reset mid-operation: the in-flight op is discarded, no response is produced, and op_count is cleared.
- op_count wraps 16'hFFFF→16'h0000 without error.

Decomposition:
- Package tf_unit_pkg:
  - op_e enum {OP_SUM, OP_DOUBLE, OP_NO_ARGS, OP_ILLEGAL} (2-bit).
  - state_e enum {IDLE, EXEC, RESP}.
  - typedef logic [7:0] byte_t.
  - typedef logic [15:0] word.
  - Constant NO_ARGS_VAL=8'd1.
- One sub-module, tf_rr_arbiter:
  - Inputs: N_REQ-wide request vector, last_grant.
  - Outputs: one-hot grant, grant index, any_req.
  - Purely combinational.
- The op evaluation lives in a function inside the scheduler.

Test Plan:
- Reset then req0 SUM a=8'd200 b=8'd100 → req_ready[0] in cycle 0, resp_valid at cycle 2, resp_data=8'd44, resp_id=0, resp_err=0, op_count=1 after handshake.
- Requester 1 DOUBLE a=8'h0B → resp_data=8'h06; requester 2 NO_ARGS → resp_data=8'd1; requester 3 op=2'b11 → resp_data=0, resp_err=1.
- All four requesters valid continuously with resp_ready=1 → grant order 0,1,2,3,0,1; a new grant every 3 cycles; never two req_ready bits high.
- resp_ready held 0 for 5 cycles → resp_valid/resp_data/resp_id stable, req_ready=0, busy=1; release → IDLE next cycle.
- Assert rst_n=0 during EXEC → outputs 0 immediately, no response after release; next request is served from requester 0 priority.
- Preload 65535 handshakes (or force op_count=16'hFFFF), then complete one op → op_count=16'h0000.

Source files
------------

// File: rtl/tf_unit_pkg.sv
// Shared types and constants for the tf_unit scheduler and its round-robin arbiter.
package tf_unit_pkg;

    typedef enum logic [1:0] {
        OP_SUM     = 2'b00,
        OP_DOUBLE  = 2'b01,
        OP_NO_ARGS = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef logic [7:0]  byte_t;
    typedef logic [15:0] word;

    localparam byte_t NO_ARGS_VAL = 8'd1;

endpackage

// File: rtl/tf_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after i_last_grant, wrapping.
module tf_rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_last_grant,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_grant_idx,
    output logic             o_any_req
);

    logic [ID_W-1:0] w_cand;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_cand      = '0;
        // Walk from the farthest candidate to the nearest so the nearest set bit wins.
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = ID_W'((int'(i_last_grant) + k) % N_REQ);
            if (i_req[w_cand]) begin
                o_grant_idx = w_cand;
            end
        end
        o_any_req = |i_req;
        if (o_any_req) begin
            o_grant[o_grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/tf_unit_sched.sv
// Shares one sum/double/no_args function unit between N_REQ requesters, one op in flight,
// with a registered result returned over a valid/ready response channel.
module tf_unit_sched
    import tf_unit_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [2*N_REQ-1:0]   req_op,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [7:0]           resp_data,
    output logic                 resp_err,
    output logic                 busy,
    output logic [15:0]          op_count
);

    state_e          r_state;
    state_e          w_state_next;
    logic [ID_W-1:0] r_last_grant;
    op_e             r_op;
    byte_t           r_a;
    byte_t           r_b;
    logic [ID_W-1:0] r_id;
    logic            r_resp_valid;
    byte_t           r_resp_data;
    logic            r_resp_err;
    logic [ID_W-1:0] r_resp_id;
    word             r_op_count;

    logic [N_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_grant_idx;
    logic             w_any_req;
    logic             w_accept;
    logic             w_handshake;
    logic [1:0]       w_op_arr [N_REQ];
    byte_t            w_a_arr  [N_REQ];
    byte_t            w_b_arr  [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_op_arr[gi] = req_op[2*gi +: 2];
            assign w_a_arr[gi]  = req_a[8*gi +: 8];
            assign w_b_arr[gi]  = req_b[8*gi +: 8];
        end
    endgenerate

    // Returns {err, data} for one operation.
    function automatic logic [8:0] eval_op(input op_e op, input byte_t a, input byte_t b);
        logic [8:0] res;
        res = '0;
        case (op)
            OP_SUM:     res = {1'b0, byte_t'(a + b)};
            OP_DOUBLE:  res = {1'b0, 4'b0000, a[2:0], 1'b0};
            OP_NO_ARGS: res = {1'b0, NO_ARGS_VAL};
            default:    res = {1'b1, 8'h00};
        endcase
        return res;
    endfunction

    tf_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx),
        .o_any_req    (w_any_req)
    );

    assign w_accept    = (r_state == IDLE) && w_any_req;
    assign w_handshake = (r_state == RESP) && resp_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_next = EXEC;
            EXEC:    w_state_next = RESP;
            RESP:    if (resp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= ID_W'(N_REQ - 1);
            r_op         <= OP_SUM;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_resp_id    <= '0;
        end else begin
            if (w_accept) begin
                r_op         <= op_e'(w_op_arr[w_grant_idx]);
                r_a          <= w_a_arr[w_grant_idx];
                r_b          <= w_b_arr[w_grant_idx];
                r_id         <= w_grant_idx;
                r_last_grant <= w_grant_idx;
            end
            if (r_state == EXEC) begin
                {r_resp_err, r_resp_data} <= eval_op(r_op, r_a, r_b);
                r_resp_id    <= r_id;
                r_resp_valid <= 1'b1;
            end
            if (w_handshake) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_handshake) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    // Grant is gated by rst_n so every output reads zero while reset is held.
    assign req_ready  = (r_state == IDLE && rst_n) ? w_grant : '0;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;
    assign resp_id    = r_resp_id;
    assign busy       = (r_state != IDLE);
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_tf_unit_sched.sv
// Directed and randomized checks of tf_unit_sched against a round-robin / arithmetic reference model.
module tb_tf_unit_sched;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready;
    logic [2*N-1:0] req_op = '0;
    logic [8*N-1:0] req_a = '0;
    logic [8*N-1:0] req_b = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic [1:0]   resp_id;
    logic [7:0]   resp_data;
    logic         resp_err;
    logic         busy;
    logic [15:0]  op_count;

    int checks = 0;
    int errors = 0;
    int m_last = N - 1;
    int m_count = 0;
    int t_op [N];
    int t_a  [N];
    int t_b  [N];

    always #5 clk = ~clk;

    tf_unit_sched #(.N_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .busy       (busy),
        .op_count   (op_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            req_op[2*i +: 2] = 2'(t_op[i]);
            req_a[8*i +: 8]  = 8'(t_a[i]);
            req_b[8*i +: 8]  = 8'(t_b[i]);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(m_last + k) % N]) return (m_last + k) % N;
        end
        return 0;
    endfunction

    function automatic logic [8:0] ref_res(input int op, input int a, input int b);
        case (op)
            0:       return {1'b0, 8'((a + b) % 256)};
            1:       return {1'b0, 8'(((a % 16) * 2) % 16)};
            2:       return {1'b0, 8'd1};
            default: return {1'b1, 8'd0};
        endcase
    endfunction

    // One full grant -> EXEC -> RESP -> handshake transaction; hold = extra stalled RESP cycles.
    task automatic serve(input logic [N-1:0] valid, input int hold);
        int g;
        logic [8:0] r;
        g = rr_pick(valid);
        r = ref_res(t_op[g], t_a[g], t_b[g]);
        @(negedge clk);
        pack();
        req_valid  = valid;
        resp_ready = (hold == 0);
        #1;
        chk("grant_ready", 32'(req_ready), 32'(1 << g));
        chk("idle_busy", 32'(busy), 0);
        @(negedge clk); #1;
        chk("exec_ready", 32'(req_ready), 0);
        chk("exec_valid", 32'(resp_valid), 0);
        chk("exec_busy", 32'(busy), 1);
        @(negedge clk); #1;
        chk("resp_valid", 32'(resp_valid), 1);
        chk("resp_id", 32'(resp_id), 32'(g));
        chk("resp_data", 32'(resp_data), 32'(r[7:0]));
        chk("resp_err", 32'(resp_err), 32'(r[8]));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            chk("hold_valid", 32'(resp_valid), 1);
            chk("hold_data", 32'(resp_data), 32'(r[7:0]));
            chk("hold_id", 32'(resp_id), 32'(g));
            chk("hold_ready", 32'(req_ready), 0);
            chk("hold_busy", 32'(busy), 1);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        m_count = (m_count + 1) % 65536;
        m_last  = g;
        chk("post_valid", 32'(resp_valid), 0);
        chk("post_busy", 32'(busy), 0);
        chk("op_count", 32'(op_count), 32'(m_count));
        $display("txn grant=%0d op=%0d a=%0h b=%0h data=%0h err=%0d count=%0d",
                 g, t_op[g], t_a[g], t_b[g], r[7:0], r[8], m_count);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            t_op[i] = 0; t_a[i] = 0; t_b[i] = 0;
        end
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 32'(resp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(op_count), 0);
        chk("rst_data", 32'(resp_data), 0);
        chk("rst_ready", 32'(req_ready), 0);
        rst_n = 1'b1;

        // Directed opcodes
        t_op[0] = 0; t_a[0] = 200;  t_b[0] = 100;
        serve(4'b0001, 0);
        t_op[1] = 1; t_a[1] = 8'h0B; t_b[1] = 8'h5A;
        serve(4'b0010, 0);
        t_op[2] = 2; t_a[2] = 8'h33; t_b[2] = 8'h44;
        serve(4'b0100, 0);
        t_op[3] = 3; t_a[3] = 8'h12; t_b[3] = 8'h34;
        serve(4'b1000, 0);

        // No request: stays idle
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("noreq_ready", 32'(req_ready), 0);
        @(negedge clk); #1;
        chk("noreq_busy", 32'(busy), 0);

        // All valid: rotation 0,1,2,3,0,1
        for (int i = 0; i < 6; i++) serve(4'b1111, 0);

        // Stalled response
        serve(4'b0001, 5);

        // Randomized
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < N; i++) begin
                t_op[i] = int'($urandom_range(0, 3));
                t_a[i]  = int'($urandom_range(0, 255));
                t_b[i]  = int'($urandom_range(0, 255));
            end
            serve(4'($urandom_range(1, 15)), int'($urandom_range(0, 2)));
        end

        // Reset during EXEC
        serve(4'b0100, 0);
        @(negedge clk);
        pack();
        req_valid = 4'b1000;
        #1;
        chk("pre_rst_grant", 32'(req_ready), 32'h8);
        @(negedge clk); #1;
        chk("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(resp_valid), 0);
        chk("mid_rst_ready", 32'(req_ready), 0);
        chk("mid_rst_count", 32'(op_count), 0);
        req_valid = '0;
        m_count = 0;
        m_last  = N - 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("post_rst_no_resp", 32'(resp_valid), 0);
        end
        serve(4'b1011, 0);

        // op_count wrap
        @(negedge clk);
        req_valid = '0;
        force dut.r_op_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_op_count;
        #1;
        chk("preload_count", 32'(op_count), 32'hFFFF);
        m_count = 65535;
        serve(4'b0001, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
